// File: rtl/uacc_pkg.sv
// Shared types and helpers for the border unary accumulator.
// Window length and saturation bounds are derived from the operand and accumulator widths.
package uacc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        WAIT_PSUM,
        OUT
    } uacc_state_t;

    localparam int WIDTH_DEF = 8;
    localparam int ACCW_DEF  = 16;

    // Temporal window: one cycle per magnitude step of a sign-magnitude operand.
    function automatic int win_len(input int width);
        return 1 << (width - 1);
    endfunction

    function automatic int sat_hi(input int accw);
        return (1 << (accw - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int accw);
        return -(1 << (accw - 1));
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed partial sum plus a sign/magnitude term, clamped to the accumulator range.
// Latency: combinational. Backpressure: none.
// Magnitude width must not exceed the accumulator width.
module sat_add
    import uacc_pkg::*;
#(
    parameter int ACCW = ACCW_DEF,
    parameter int MAGW = WIDTH_DEF
) (
    input  logic signed [ACCW-1:0] a,
    input  logic        [MAGW-1:0] mag,
    input  logic                   neg,
    output logic signed [ACCW-1:0] sum
);

    localparam int HI_I = sat_hi(ACCW);
    localparam int LO_I = sat_lo(ACCW);
    localparam logic signed [ACCW:0] HI = HI_I[ACCW:0];
    localparam logic signed [ACCW:0] LO = LO_I[ACCW:0];

    logic signed [ACCW:0] a_ext;
    logic signed [ACCW:0] m_ext;
    logic signed [ACCW:0] raw;

    // One guard bit is enough: |mag| <= 2^(ACCW-1) keeps raw inside ACCW+1 bits.
    always_comb begin
        a_ext = {a[ACCW-1], a};
        m_ext = {{(ACCW + 1 - MAGW){1'b0}}, mag};
        if (neg) begin
            m_ext = -m_ext;
        end
        raw = a_ext + m_ext;
        if (raw > HI) begin
            sum = HI[ACCW-1:0];
        end else if (raw < LO) begin
            sum = LO[ACCW-1:0];
        end else begin
            sum = raw[ACCW-1:0];
        end
    end

endmodule

// File: rtl/uacc_border.sv
// Counts product bits over one 2^(WIDTH-1)-cycle window, signs them, adds the upstream psum.
// Latency: init in cycle 0 -> psum accepted from cycle N+1 -> o_psum_valid from cycle N+2.
// Backpressure: o_psum held in OUT until i_psum_ready; upstream stalls until WAIT_PSUM.
module uacc_border
    import uacc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACCW  = ACCW_DEF
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   init,
    input  logic                   clr,
    input  logic                   i_bit,
    input  logic                   i_sign,
    input  logic signed [ACCW-1:0] i_psum,
    input  logic                   i_psum_valid,
    output logic                   o_psum_ready,
    output logic signed [ACCW-1:0] o_psum,
    output logic                   o_psum_valid,
    input  logic                   i_psum_ready,
    output logic                   o_overrun
);

    localparam int N      = win_len(WIDTH);
    localparam int LAST_I = N - 1;
    localparam logic [WIDTH-1:0] LAST = LAST_I[WIDTH-1:0];

    uacc_state_t state;
    uacc_state_t state_d;

    logic [WIDTH-1:0]       win_cnt;
    logic [WIDTH-1:0]       bit_cnt;
    logic                   sign_q;
    logic                   psum_take;
    logic                   busy;
    logic                   win_start;
    logic signed [ACCW-1:0] sum_sat;

    assign busy      = (state == WAIT_PSUM) || (state == OUT);
    assign win_start = init && !clr && ((state == IDLE) || (state == ACCUM));
    assign psum_take = o_psum_ready && i_psum_valid;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Handshake outputs are masked by clr so an aborted cycle never completes a transfer.
    always_comb begin
        state_d      = state;
        o_psum_ready = 1'b0;
        o_psum_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (init) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!init && (win_cnt == LAST)) begin
                    state_d = WAIT_PSUM;
                end
            end
            WAIT_PSUM: begin
                o_psum_ready = 1'b1;
                if (i_psum_valid) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                o_psum_valid = 1'b1;
                if (i_psum_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
        if (clr) begin
            state_d      = IDLE;
            o_psum_ready = 1'b0;
            o_psum_valid = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt   <= '0;
            bit_cnt   <= '0;
            sign_q    <= 1'b0;
            o_psum    <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= init && !clr && busy;
            if (clr) begin
                win_cnt <= '0;
                bit_cnt <= '0;
            end else if (win_start) begin
                win_cnt <= '0;
                bit_cnt <= '0;
                sign_q  <= i_sign;
            end else if (state == ACCUM) begin
                win_cnt <= win_cnt + 1'b1;
                bit_cnt <= bit_cnt + {{(WIDTH - 1){1'b0}}, i_bit};
            end
            if (psum_take) begin
                o_psum <= sum_sat;
            end
        end
    end

    sat_add #(
        .ACCW (ACCW),
        .MAGW (WIDTH)
    ) u_sat_add (
        .a   (i_psum),
        .mag (bit_cnt),
        .neg (sign_q),
        .sum (sum_sat)
    );

endmodule

// File: tb/tb_uacc_border.sv
// Bench for uacc_border: a 16-bit and an 8-bit accumulator share one control stream;
// expected partial sums are queued at stimulus time and popped when each output handshakes.
module tb_uacc_border;

    localparam int WIDTH = 8;
    localparam int N     = 1 << (WIDTH - 1);

    logic clock;
    logic rst_n;
    logic init;
    logic clr;
    logic i_bit;
    logic i_sign;
    logic i_psum_valid;
    logic i_psum_ready;

    logic signed [15:0] i_psum16;
    logic signed [15:0] o_psum16;
    logic               o_psum_ready16;
    logic               o_psum_valid16;
    logic               o_overrun16;

    logic signed [7:0]  i_psum8;
    logic signed [7:0]  o_psum8;
    logic               o_psum_ready8;
    logic               o_psum_valid8;
    logic               o_overrun8;

    int tests_run;
    int tests_failed;
    int ovr16;
    int q16[$];
    int q8[$];

    uacc_border #(.WIDTH(WIDTH), .ACCW(16)) dut16 (
        .clock        (clock),
        .rst_n        (rst_n),
        .init         (init),
        .clr          (clr),
        .i_bit        (i_bit),
        .i_sign       (i_sign),
        .i_psum       (i_psum16),
        .i_psum_valid (i_psum_valid),
        .o_psum_ready (o_psum_ready16),
        .o_psum       (o_psum16),
        .o_psum_valid (o_psum_valid16),
        .i_psum_ready (i_psum_ready),
        .o_overrun    (o_overrun16)
    );

    uacc_border #(.WIDTH(WIDTH), .ACCW(8)) dut8 (
        .clock        (clock),
        .rst_n        (rst_n),
        .init         (init),
        .clr          (clr),
        .i_bit        (i_bit),
        .i_sign       (i_sign),
        .i_psum       (i_psum8),
        .i_psum_valid (i_psum_valid),
        .o_psum_ready (o_psum_ready8),
        .o_psum       (o_psum8),
        .o_psum_valid (o_psum_valid8),
        .i_psum_ready (i_psum_ready),
        .o_overrun    (o_overrun8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (actual: still running, required: finished)");
        $fatal(1, "watchdog");
    end

    function automatic int sat_model(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Scoreboard: pop on every completed output handshake.
    always @(negedge clock) begin
        if (rst_n && o_overrun16) ovr16++;
        if (rst_n && !clr && o_psum_valid16 && i_psum_ready) begin
            tests_run++;
            if (q16.size() == 0) begin
                tests_failed++;
                $display("FAIL sb16: unexpected output %0d (required: none)", o_psum16);
            end else begin
                int e;
                e = q16.pop_front();
                if (int'(o_psum16) !== e) begin
                    tests_failed++;
                    $display("FAIL sb16: o_psum %0d, required %0d", o_psum16, e);
                end
            end
        end
        if (rst_n && !clr && o_psum_valid8 && i_psum_ready) begin
            tests_run++;
            if (q8.size() == 0) begin
                tests_failed++;
                $display("FAIL sb8: unexpected output %0d (required: none)", o_psum8);
            end else begin
                int e;
                e = q8.pop_front();
                if (int'(o_psum8) !== e) begin
                    tests_failed++;
                    $display("FAIL sb8: o_psum %0d, required %0d", o_psum8, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives init (cycle 0) and N product bits; returns in cycle N+1.
    task automatic drive_window(input logic s, input int mode, input int p16, input int p8,
                                input logic early);
        int   ones;
        logic b;
        ones         = 0;
        i_psum16     = 16'(p16);
        i_psum8      = 8'(p8);
        i_psum_valid = early;
        init         = 1'b1;
        i_sign       = s;
        tick();
        init   = 1'b0;
        i_sign = 1'b0;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       b = 1'b0;
                1:       b = (i % 3 == 0) && (i < 120);
                default: b = 1'b1;
            endcase
            i_bit = b;
            ones += int'(b);
            tick();
        end
        i_bit = 1'b0;
        q16.push_back(sat_model(p16 + (s ? -ones : ones), 16));
        q8.push_back(sat_model(p8 + (s ? -ones : ones), 8));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clock);
        tests_run++;
        if (o_psum16 !== 16'sd0 || o_psum_valid16 !== 1'b0 || o_psum_ready16 !== 1'b0 ||
            o_overrun16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset16: psum %0d valid %b ready %b ovr %b, required 0 0 0 0",
                     o_psum16, o_psum_valid16, o_psum_ready16, o_overrun16);
        end
        tests_run++;
        if (o_psum8 !== 8'sd0 || o_psum_valid8 !== 1'b0 || o_psum_ready8 !== 1'b0 ||
            o_overrun8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset8: psum %0d valid %b ready %b ovr %b, required 0 0 0 0",
                     o_psum8, o_psum_valid8, o_psum_ready8, o_overrun8);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Early psum, ready high: checks the exact output cycle and one-cycle valid.
    task automatic test_window(input string name, input logic s, input int mode,
                               input int p16, input int p8);
        i_psum_ready = 1'b1;
        drive_window(s, mode, p16, p8, 1'b1);
        @(negedge clock);
        tests_run++;
        if (o_psum_ready16 !== 1'b1 || o_psum_valid16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_cycN1: ready %b valid %b, required 1 0", name,
                     o_psum_ready16, o_psum_valid16);
        end
        tick();
        i_psum_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if (o_psum_valid16 !== 1'b1 || o_psum_valid8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_cycN2: valid16 %b valid8 %b, required 1 1", name,
                     o_psum_valid16, o_psum_valid8);
        end
        tick();
        @(negedge clock);
        tests_run++;
        if (o_psum_valid16 !== 1'b0 || o_psum_ready16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_cycN3: valid %b ready %b, required 0 0", name,
                     o_psum_valid16, o_psum_ready16);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int ovr0;
        i_psum_ready = 1'b0;
        drive_window(1'b0, 1, 300, -5, 1'b1);
        tick();
        i_psum_valid = 1'b0;
        ovr0 = ovr16;
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            tests_run++;
            if (o_psum_valid16 !== 1'b1 || int'(o_psum16) != q16[0] ||
                int'(o_psum8) != q8[0]) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: valid %b psum16 %0d psum8 %0d, required 1 %0d %0d",
                         j, o_psum_valid16, o_psum16, o_psum8, q16[0], q8[0]);
            end
            tick();
            init = (j == 1);
        end
        tests_run++;
        if (ovr16 - ovr0 != 1) begin
            tests_failed++;
            $display("FAIL bp_overrun: pulses %0d, required 1", ovr16 - ovr0);
        end
        i_psum_ready = 1'b1;
        tick();
        @(negedge clock);
        tests_run++;
        if (o_psum_valid16 !== 1'b0 || o_psum_ready16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_idle: valid %b ready %b, required 0 0", o_psum_valid16,
                     o_psum_ready16);
        end
        tick();
    endtask

    task automatic test_late_psum();
        int bad;
        bad          = 0;
        i_psum_ready = 1'b1;
        drive_window(1'b1, 2, 1000, 3, 1'b0);
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            if (o_psum_ready16 !== 1'b1 || o_psum_valid16 !== 1'b0) bad++;
            tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL late_wait: bad cycles %0d, required 0", bad);
        end
        i_psum_valid = 1'b1;
        tick();
        i_psum_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if (o_psum_valid16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL late_out: valid %b, required 1", o_psum_valid16);
        end
        tick();
    endtask

    task automatic test_clr();
        int bad;
        bad          = 0;
        i_psum_ready = 1'b1;
        init         = 1'b1;
        i_sign       = 1'b0;
        tick();
        init = 1'b0;
        for (int i = 0; i < 50; i++) begin
            i_bit = 1'b1;
            tick();
        end
        clr = 1'b1;
        tick();
        clr          = 1'b0;
        i_psum_valid = 1'b1;
        for (int j = 0; j < N + 10; j++) begin
            @(negedge clock);
            if (o_psum_ready16 !== 1'b0 || o_psum_valid16 !== 1'b0) bad++;
            tick();
        end
        i_bit        = 1'b0;
        i_psum_valid = 1'b0;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL clr_accum: active cycles %0d, required 0", bad);
        end
        // Abort in WAIT_PSUM with valid high: no transfer may complete.
        drive_window(1'b0, 2, 1, 1, 1'b0);
        void'(q16.pop_back());
        void'(q8.pop_back());
        clr          = 1'b1;
        i_psum_valid = 1'b1;
        @(negedge clock);
        tests_run++;
        if (o_psum_ready16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_wait_rdy: ready %b, required 0", o_psum_ready16);
        end
        tick();
        clr = 1'b0;
        @(negedge clock);
        tests_run++;
        if (o_psum_ready16 !== 1'b0 || o_psum_valid16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_wait_idle: ready %b valid %b, required 0 0", o_psum_ready16,
                     o_psum_valid16);
        end
        i_psum_valid = 1'b0;
        tick();
    endtask

    task automatic test_restart();
        int ovr0;
        ovr0         = ovr16;
        i_psum_ready = 1'b1;
        init         = 1'b1;
        i_sign       = 1'b1;
        tick();
        init = 1'b0;
        for (int i = 0; i < 59; i++) begin
            i_bit = 1'b1;
            tick();
        end
        drive_window(1'b0, 1, 0, 0, 1'b1);
        @(negedge clock);
        tests_run++;
        if (o_psum_ready16 !== 1'b1 || o_psum_valid16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_cyc: ready %b valid %b, required 1 0", o_psum_ready16,
                     o_psum_valid16);
        end
        tick();
        i_psum_valid = 1'b0;
        tick();
        tests_run++;
        if (ovr16 != ovr0) begin
            tests_failed++;
            $display("FAIL restart_ovr: pulses %0d, required 0", ovr16 - ovr0);
        end
    endtask

    task automatic test_reset_out();
        i_psum_ready = 1'b0;
        drive_window(1'b0, 1, 7, 7, 1'b1);
        tick();
        i_psum_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if (o_psum_valid16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre: valid %b, required 1", o_psum_valid16);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (o_psum_valid16 !== 1'b0 || o_psum16 !== 16'sd0 || o_psum_valid8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_out: valid16 %b psum16 %0d valid8 %b, required 0 0 0",
                     o_psum_valid16, o_psum16, o_psum_valid8);
        end
        void'(q16.pop_back());
        void'(q8.pop_back());
        tick();
        rst_n        = 1'b1;
        i_psum_ready = 1'b1;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ovr16        = 0;
        init         = 1'b0;
        clr          = 1'b0;
        i_bit        = 1'b0;
        i_sign       = 1'b0;
        i_psum16     = '0;
        i_psum8      = '0;
        i_psum_valid = 1'b0;
        i_psum_ready = 1'b1;
        test_reset();
        test_window("pos40", 1'b0, 1, 100, 100);
        test_window("neg40", 1'b1, 1, 10, 10);
        test_window("zero", 1'b1, 0, -7, -7);
        test_window("sat_hi", 1'b0, 2, 120, 120);
        test_window("sat_lo", 1'b1, 2, -120, -120);
        test_backpressure();
        test_late_psum();
        test_clr();
        test_restart();
        test_reset_out();
        tests_run++;
        if (q16.size() != 0 || q8.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: pending %0d/%0d, required 0/0", q16.size(), q8.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
